regfile_wr_arbiter: RTL and testbench

//  Owns the register file's single write port. Arbitrates between the in-order writeback stage (W) and a

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/regfile_wr_arbiter_wb_fifo.sv | 67 ++++++
 rtl/regfile_wr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared datapath constants and the writeback request type used by the
// register-file write arbiter and its result FIFO.
//   XLEN        datapath width
//   REG_ADDR_W  register index width (32 architectural registers)
//   wb_req_t    one register-file write: destination index plus data
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // x0 is hardwired to zero; writes to it are architecturally discarded.
    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
        return (addr == {REG_ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Small synchronous FIFO of wb_req_t entries holding multi-cycle results that
// are waiting for a free register-file write slot. The head entry is visible
// combinationally; pop consumes it at the clock edge.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, push_req  enqueue push_req at the edge (caller never pushes when full)
//   pop             dequeue the head at the edge (caller never pops when empty)
//   head            current head entry (undefined content when empty)
//   full, empty     occupancy flags
// -----------------------------------------------------------------------------
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wb_req_t push_req,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t         mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; content needs no reset because occupancy gates its use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= push_req;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = (count_r == (AW+1)'(DEPTH));
    assign empty = (count_r == {(AW+1){1'b0}});

endmodule

// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
// Owns the single register-file write port. The in-order writeback stage (W)
// always wins; multi-cycle (MUL/DIV) results arrive through a valid/ready
// handshake, are buffered in wb_fifo and written when W leaves the port free.
// A per-register pending scoreboard stalls decode on RAW/WAW hazards against
// outstanding multi-cycle ops, and a starvation counter requests a one-bubble
// pipeline hold when buffered results wait too long.
// XLEN comes from riscv_pkg.
// Configuration macro: RF_WR_BYPASS_EN -- when defined, an accepted result
// writes straight through in the same cycle if the FIFO is empty and W is idle
// (or writing x0). Undefined (default): every result goes through the FIFO.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   i_result_W / _wr_addr_W / _wr_en_W writeback write request
//   i_mc_valid, o_mc_ready, i_mc_data, i_mc_addr   multi-cycle result handshake
//   i_issue_mc_en, i_issue_mc_addr    decode issues a multi-cycle op
//   i_rs1_addr_D, i_rs2_addr_D, i_rd_addr_D        decode hazard check
//   o_stall_D                         decode stall (combinational)
//   o_stall_req                       registered one-cycle bubble request
//   o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data         register-file write port
// -----------------------------------------------------------------------------
module regfile_wr_arbiter
    import riscv_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       i_result_W,
    input  logic [REG_ADDR_W-1:0] i_register_file_wr_addr_W,
    input  logic                  i_register_file_wr_en_W,
    input  logic                  i_mc_valid,
    output logic                  o_mc_ready,
    input  logic [XLEN-1:0]       i_mc_data,
    input  logic [REG_ADDR_W-1:0] i_mc_addr,
    input  logic                  i_issue_mc_en,
    input  logic [REG_ADDR_W-1:0] i_issue_mc_addr,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr_D,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr_D,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_D,
    output logic                  o_stall_D,
    output logic                  o_stall_req,
    output logic                  o_rf_wr_en,
    output logic [REG_ADDR_W-1:0] o_rf_wr_addr,
    output logic [XLEN-1:0]       o_rf_wr_data
);

    localparam int NREG = 1 << REG_ADDR_W;
    localparam int CW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    logic            w_win_s;
    logic            mc_ready_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            fifo_push_s;
    logic            fifo_pop_s;
    logic            bypass_s;
    wb_req_t         fifo_head_s;
    wb_req_t         mc_req_s;
    logic [NREG-1:0] pending_r;
    logic [NREG-1:0] pending_nxt_s;
    logic [NREG-1:0] clr_mask_s;
    logic [NREG-1:0] set_mask_s;
    logic [CW-1:0]   starve_cnt_r;
    logic [CW-1:0]   starve_cnt_nxt_s;
    logic            stall_req_r;

    assign mc_req_s = '{addr: i_mc_addr, data: i_mc_data};

    wb_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_wb_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push_s),
        .push_req (mc_req_s),
        .pop      (fifo_pop_s),
        .head     (fifo_head_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s)
    );

    // Port ownership: W (non-x0) first, then FIFO head, then optional bypass.
    // Ready depends only on the registered full flag, so a same-cycle pop
    // of a full FIFO does not raise it until the next cycle.
    always_comb begin
        w_win_s    = i_register_file_wr_en_W && !is_x0(i_register_file_wr_addr_W);
        mc_ready_s = !rst && !fifo_full_s;
        fifo_pop_s = !rst && !fifo_empty_s && !w_win_s;
`ifdef RF_WR_BYPASS_EN
        bypass_s   = !rst && fifo_empty_s && !w_win_s && i_mc_valid && mc_ready_s;
`else
        bypass_s   = 1'b0;
`endif
        fifo_push_s = i_mc_valid && mc_ready_s && !bypass_s;
    end

    // Register-file write mux; x0 destinations still consume their slot.
    always_comb begin
        o_rf_wr_en   = 1'b0;
        o_rf_wr_addr = {REG_ADDR_W{1'b0}};
        o_rf_wr_data = {XLEN{1'b0}};
        if (rst) begin
            o_rf_wr_en = 1'b0;
        end else if (w_win_s) begin
            o_rf_wr_en   = 1'b1;
            o_rf_wr_addr = i_register_file_wr_addr_W;
            o_rf_wr_data = i_result_W;
        end else if (fifo_pop_s) begin
            o_rf_wr_en   = !is_x0(fifo_head_s.addr);
            o_rf_wr_addr = fifo_head_s.addr;
            o_rf_wr_data = fifo_head_s.data;
        end else if (bypass_s) begin
            o_rf_wr_en   = !is_x0(i_mc_addr);
            o_rf_wr_addr = i_mc_addr;
            o_rf_wr_data = i_mc_data;
        end else begin
            o_rf_wr_en = 1'b0;
        end
    end

    // Scoreboard next state: set applied after clear so a same-register
    // issue keeps the bit pending; bit 0 is forced low.
    always_comb begin
        clr_mask_s = {NREG{1'b0}};
        set_mask_s = {NREG{1'b0}};
        if (fifo_pop_s) begin
            clr_mask_s[fifo_head_s.addr] = 1'b1;
        end else if (bypass_s) begin
            clr_mask_s[i_mc_addr] = 1'b1;
        end else begin
            clr_mask_s = {NREG{1'b0}};
        end
        if (i_issue_mc_en && !is_x0(i_issue_mc_addr)) begin
            set_mask_s[i_issue_mc_addr] = 1'b1;
        end else begin
            set_mask_s = {NREG{1'b0}};
        end
        pending_nxt_s = ((pending_r & ~clr_mask_s) | set_mask_s) & ~NREG'(1);
    end

    // Starvation counter: counts undrained non-empty cycles, saturating.
    always_comb begin
        starve_cnt_nxt_s = starve_cnt_r;
        if (fifo_empty_s || fifo_pop_s) begin
            starve_cnt_nxt_s = {CW{1'b0}};
        end else if (starve_cnt_r != LIMIT_C) begin
            starve_cnt_nxt_s = starve_cnt_r + CW'(1);
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
    end

    // State registers. The bubble request is a single-cycle pulse; while the
    // counter stays saturated it re-fires every other cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r    <= {NREG{1'b0}};
            starve_cnt_r <= {CW{1'b0}};
            stall_req_r  <= 1'b0;
        end else begin
            pending_r    <= pending_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
            stall_req_r  <= (starve_cnt_nxt_s == LIMIT_C) && !stall_req_r;
        end
    end

    assign o_mc_ready  = mc_ready_s;
    assign o_stall_req = stall_req_r;
    assign o_stall_D   = !rst && (pending_r[i_rs1_addr_D] |
                                  pending_r[i_rs2_addr_D] |
                                  pending_r[i_rd_addr_D]);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
// Self-checking bench: directed scenarios followed by randomized traffic,
// every cycle compared against a queue-based reference model of the write
// port, scoreboard and starvation behaviour.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;
    import riscv_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] result_W;
    logic [4:0]  wr_addr_W;
    logic        wr_en_W;
    logic        mc_valid;
    logic        mc_ready;
    logic [31:0] mc_data;
    logic [4:0]  mc_addr;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic [4:0]  rs1, rs2, rd;
    logic        stall_D;
    logic        stall_req;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .i_result_W                (result_W),
        .i_register_file_wr_addr_W (wr_addr_W),
        .i_register_file_wr_en_W   (wr_en_W),
        .i_mc_valid                (mc_valid),
        .o_mc_ready                (mc_ready),
        .i_mc_data                 (mc_data),
        .i_mc_addr                 (mc_addr),
        .i_issue_mc_en             (issue_en),
        .i_issue_mc_addr           (issue_addr),
        .i_rs1_addr_D              (rs1),
        .i_rs2_addr_D              (rs2),
        .i_rd_addr_D               (rd),
        .o_stall_D                 (stall_D),
        .o_stall_req               (stall_req),
        .o_rf_wr_en                (rf_wr_en),
        .o_rf_wr_addr              (rf_wr_addr),
        .o_rf_wr_data              (rf_wr_data)
    );

    // Reference model state
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [31:0] pend;
    int          run;
    bit          m_stall;
    bit          last_exp_stall;
    bit          last_pushed;
    int          tests = 0;
    int          fails = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; result_W = 32'd0; wr_addr_W = 5'd0; wr_en_W = 1'b0;
        mc_valid = 1'b0; mc_data = 32'd0; mc_addr = 5'd0;
        issue_en = 1'b0; issue_addr = 5'd0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    endtask

    // Called 1 time unit after a rising edge with inputs already driven.
    task automatic run_cycle();
        bit          w_win, exp_ready, exp_en, popped, bypassed, pushed, undrained, exp_sd;
        logic [4:0]  exp_a;
        logic [31:0] exp_d;
        ent_t        e;
        #2;
        exp_ready = !rst && (q.size() < DEPTH);
        w_win     = wr_en_W && (wr_addr_W != 5'd0);
        popped    = !rst && !w_win && (q.size() > 0);
        bypassed  = 1'b0;
`ifdef RF_WR_BYPASS_EN
        bypassed  = !rst && (q.size() == 0) && !w_win && mc_valid && exp_ready;
`endif
        exp_en = 1'b0; exp_a = 5'd0; exp_d = 32'd0;
        if (!rst && w_win) begin
            exp_en = 1'b1; exp_a = wr_addr_W; exp_d = result_W;
        end else if (popped) begin
            e = q[0];
            exp_en = (e.a != 5'd0); exp_a = e.a; exp_d = e.d;
        end else if (bypassed) begin
            exp_en = (mc_addr != 5'd0); exp_a = mc_addr; exp_d = mc_data;
        end
        exp_sd = !rst && (pend[rs1] || pend[rs2] || pend[rd]);

        check_eq("mc_ready",  32'(mc_ready),  32'(exp_ready));
        check_eq("rf_wr_en",  32'(rf_wr_en),  32'(exp_en));
        if (exp_en) begin
            check_eq("rf_wr_addr", 32'(rf_wr_addr), 32'(exp_a));
            check_eq("rf_wr_data", rf_wr_data, exp_d);
        end
        check_eq("stall_D",   32'(stall_D),   32'(exp_sd));
        check_eq("stall_req", 32'(stall_req), 32'(m_stall));
        last_exp_stall = m_stall;

        if (rst) begin
            q.delete(); pend = 32'd0; run = 0; m_stall = 1'b0; last_pushed = 1'b0;
        end else begin
            undrained = (q.size() > 0) && !popped;
            if (popped) begin
                pend[q[0].a] = 1'b0;
                void'(q.pop_front());
            end
            if (bypassed) pend[mc_addr] = 1'b0;
            pushed = mc_valid && exp_ready && !bypassed;
            last_pushed = pushed;
            if (pushed) q.push_back('{mc_addr, mc_data});
            if (issue_en && issue_addr != 5'd0) pend[issue_addr] = 1'b1;
            pend[0] = 1'b0;
            run     = undrained ? run + 1 : 0;
            m_stall = undrained && (run >= LIMIT) && (((run - LIMIT) % 2) == 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit bubble;
        int idx;
        idle_inputs();
        pend = 32'd0; run = 0; m_stall = 1'b0; last_exp_stall = 1'b0; last_pushed = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: reset held with valid high -> nothing accepted
        rst = 1'b1; mc_valid = 1'b1; mc_addr = 5'd3; mc_data = 32'h1234_5678;
        run_cycle(); run_cycle();
        idle_inputs();
        run_cycle();

        // 2: idle W, push x5 while decode reads x5
        issue_en = 1'b1; issue_addr = 5'd5; run_cycle();
        idle_inputs(); rs2 = 5'd5;
        mc_valid = 1'b1; mc_addr = 5'd5; mc_data = 32'hDEAD_BEEF; run_cycle();
        mc_valid = 1'b0; run_cycle(); run_cycle();

        // 3: collision, W writes x7 each cycle; bubble follows stall_req
        idle_inputs();
        wr_en_W = 1'b1; wr_addr_W = 5'd7; result_W = 32'h0000_0077;
        mc_valid = 1'b1; mc_addr = 5'd6; mc_data = 32'h0000_0066; run_cycle();
        mc_valid = 1'b0; bubble = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_en_W = !bubble; run_cycle(); bubble = last_exp_stall;
        end

        // 4: fill FIFO while W busy; hold the third valid until accepted
        idle_inputs(); idx = 0;
        for (int i = 0; i < 10; i++) begin
            wr_en_W = (i < 5); wr_addr_W = 5'd1; result_W = 32'(i);
            mc_valid = (idx < 3); mc_addr = 5'(10 + idx); mc_data = 32'hA000_0000 + 32'(idx);
            run_cycle();
            if (last_pushed) idx++;
        end

        // 5: scoreboard hazard on x9, same-cycle set and clear
        idle_inputs();
        issue_en = 1'b1; issue_addr = 5'd9; run_cycle();
        issue_en = 1'b0; rs2 = 5'd9; wr_en_W = 1'b1; wr_addr_W = 5'd2;
        mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'h9999_0001; run_cycle();
        mc_valid = 1'b0; run_cycle();
        wr_en_W = 1'b0; issue_en = 1'b1; issue_addr = 5'd9; run_cycle();
        issue_en = 1'b0; run_cycle();
        mc_valid = 1'b1; mc_data = 32'h9999_0002; run_cycle();
        mc_valid = 1'b0; run_cycle(); run_cycle();

        // 6: x0 issue and push
        idle_inputs();
        issue_en = 1'b1; issue_addr = 5'd0; rs1 = 5'd0;
        wr_en_W = 1'b1; wr_addr_W = 5'd4;
        mc_valid = 1'b1; mc_addr = 5'd0; mc_data = 32'hFFFF_0000; run_cycle();
        idle_inputs(); run_cycle(); run_cycle();

        // Randomized traffic, mostly honoring the bubble request
        bubble = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            wr_en_W    = (bubble && ($urandom_range(0, 3) != 0)) ? 1'b0 : 1'($urandom_range(0, 1));
            wr_addr_W  = 5'($urandom_range(0, 31));
            result_W   = $urandom();
            mc_valid   = 1'($urandom_range(0, 1));
            mc_addr    = 5'($urandom_range(0, 31));
            mc_data    = $urandom();
            issue_en   = ($urandom_range(0, 3) == 0);
            issue_addr = 5'($urandom_range(0, 31));
            rs1        = 5'($urandom_range(0, 31));
            rs2        = 5'($urandom_range(0, 31));
            rd         = 5'($urandom_range(0, 31));
            run_cycle();
            bubble = last_exp_stall;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
